vec_wb_merge: RTL and testbench
===============================

# vec_wb_merge

Vector writeback stage that sits directly downstream of the vector ALU. It takes the full-width result the ALU presents when its `done` rises, merges it element by element with the old destination register contents under vstart/vl/v0-mask/tail policy, and writes the merged register to the vector register file through a valid/ready port. It processes one 32-bit word per cycle and pulses `wb_done` when the write has been accepted.

## Interface
- `VLEN`, 128, vector register width in bits; multiple of 32.
- `clk`  in  1  clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `alu_done`  in  1  ALU result valid; level, held high while the ALU `run` is high.
- `alu_vd`  in  VLEN  ALU result register.
- `old_vd`  in  VLEN  current contents of the destination register.
- `v0_mask`  in  VLEN  mask register v0; bit i masks element i.
- `vm`  in  1  1 = unmasked operation.
- `vsew`  in  3  element width code: 000 = 8, 001 = 16, 010 = 32 bits; other codes are treated as 010.
- `vl`, `vstart`  in  10 each  vector length and start element.
- `vta`, `vma`  in  1 each  tail-agnostic and mask-agnostic policy bits.
- `vd_addr`  in  5  destination register number.
- `wr_valid`  out  1  write request to the register file.
- `wr_addr`  out  5  register number for the write.
- `wr_data`  out  VLEN  merged register value.
- `wr_ready`  in  1  register file accepts the write.
- `alu_ack`  out  1  one-cycle pulse: result consumed, upstream may drop `run`.
- `busy`  out  1  high in every state except IDLE.
- `wb_done`  out  1  one-cycle completion pulse.

## Operation
- States: IDLE, MERGE, WRITE, DONE.
- Armed flag: set by reset and whenever `alu_done` is seen low in IDLE. Capture requires the flag to be set, so a single held `alu_done` level is never captured twice.
- IDLE, with `alu_done` high and armed set:
  - Latch all inputs, clear armed.
  - Compute VLMAX = VLEN >> (sew+3) and eff_vl = min(vl, VLMAX).
  - If `vstart` >= eff_vl, go to DONE. No write occurs and the register is left untouched.
  - Otherwise go to MERGE with word counter w = 0.
- MERGE: one 32-bit word w per cycle; elements per word = 4 >> sew. Rule for each element index i:
  - i < vstart: keep the old value.
  - vstart <= i < eff_vl:
    - active (`vm` = 1 or `v0_mask[i]` = 1): take the ALU value;
    - inactive: all-ones if `vma`, otherwise the old value.
  - i >= eff_vl: all-ones if `vta`, otherwise the old value.
  - After w = VLEN/32 - 1, go to WRITE.
- WRITE:
  - `wr_valid` = 1 with `wr_addr`/`wr_data` stable until `wr_valid && wr_ready`.
  - On that handshake, go to DONE.
- DONE: `wb_done` = 1 and `alu_ack` = 1 for exactly one cycle, then IDLE.
- Input changes after capture have no effect on the operation in flight.

## Timing
- Reset values: `wr_valid` 0, `wr_addr` 0, `wr_data` 0, `alu_ack` 0, `busy` 0, `wb_done` 0, state IDLE, armed 1.
- Capture edge → first MERGE cycle: 1 cycle. MERGE takes VLEN/32 cycles (4 at VLEN = 128).
- `wr_valid` rises on the edge after the last MERGE word.
- With `wr_ready` tied high: `wb_done` comes VLEN/32 + 2 cycles after the capture edge. Each stall cycle adds 1.
- Skip path (vstart >= eff_vl): `wb_done` one cycle after capture.
- `wr_ready` high while `wr_valid` is low is ignored.
- `resetn` low mid-operation: immediate return to IDLE with all outputs at reset values. A partial write is never issued and no `wb_done` follows.
- `alu_done` dropping after capture does not abort the operation.

## Configuration
- `VEC_WB_MASK_EN` defined: `vm`/`v0_mask` are honoured as above.
- Not defined: every body element is active; `v0_mask`, `vm` and `vma` are ignored and the mask logic is not synthesised.

## Test plan
- sew = 8, vl = 16, vstart = 0, vm = 1, `alu_vd` = 0x0F..0F, `old_vd` = 0 → `wr_data` = 0x0F..0F; `wb_done` 6 cycles after capture.
- sew = 32, vl = 2, vta = 1, `old_vd` = 0 → words 0–1 = ALU value, words 2–3 = 0xFFFFFFFF. Repeat with vta = 0 → words 2–3 = 0.
- sew = 16, vm = 0, `v0_mask` = 0x00AA, vma = 0, vl = 8 → odd halfwords from the ALU, even halfwords from `old_vd`. Without `VEC_WB_MASK_EN` → all 8 from the ALU.
- vstart = 5, vl = 5 → no `wr_valid`; `wb_done` 1 cycle after capture. Holding `alu_done` high afterwards produces no second capture until it drops and rises again.
- `wr_ready` low for 3 cycles → `wr_valid`/`wr_data` stable throughout; `wb_done` delayed by 3 cycles.
- `resetn` pulsed low during MERGE word 2 → all outputs 0 at once; no `wr_valid` afterwards.

Source files
------------

// File: rtl/vec_wb_merge.sv
// Vector writeback merge: combines the ALU result with the old vd under vstart/vl/mask/tail
// policy, one 32-bit word per cycle, then writes it through a valid/ready port. Optional: VEC_WB_MASK_EN.
module vec_wb_merge #(
  parameter int VLEN = 128
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            alu_done,
  input  logic [VLEN-1:0] alu_vd,
  input  logic [VLEN-1:0] old_vd,
  input  logic [VLEN-1:0] v0_mask,
  input  logic            vm,
  input  logic [2:0]      vsew,
  input  logic [9:0]      vl,
  input  logic [9:0]      vstart,
  input  logic            vta,
  input  logic            vma,
  input  logic [4:0]      vd_addr,
  output logic            wr_valid,
  output logic [4:0]      wr_addr,
  output logic [VLEN-1:0] wr_data,
  input  logic            wr_ready,
  output logic            alu_ack,
  output logic            busy,
  output logic            wb_done
);
  localparam int NW = VLEN / 32;
  localparam int WW = (NW > 1) ? $clog2(NW) : 1;
  localparam int IW = $clog2(VLEN);
  localparam logic [WW-1:0] LAST_W = WW'(NW - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, MERGE = 2'd1, WRITE = 2'd2, DONE = 2'd3} state_t;
  state_t state_r, state_n;

  logic            armed_r, capture_s, skip_s;
  logic [1:0]      sew_s, sew_r;
  logic [10:0]     vlmax_s;
  logic [9:0]      eff_vl_s, eff_vl_r, vstart_r;
  logic [VLEN-1:0] alu_r, old_r;
  logic            vta_r;
  logic [WW-1:0]   w_r;
  logic [31:0]     alu_w_s, old_w_s, merged_s;
  logic [9:0]      elem_s;
  logic            act_s, inact_ones_s;
`ifdef VEC_WB_MASK_EN
  logic [VLEN-1:0] mask_r;
  logic            vm_r, vma_r;
`else
  logic            unused_s;
  assign unused_s = ^{vm, vma, v0_mask};
`endif

  // Normalise the element width code; reserved codes behave as 32-bit.
  always_comb begin
    case (vsew)
      3'b000:  sew_s = 2'd0;
      3'b001:  sew_s = 2'd1;
      default: sew_s = 2'd2;
    endcase
  end

  assign vlmax_s  = 11'((VLEN / 8) >> sew_s);
  assign eff_vl_s = ({1'b0, vl} < vlmax_s) ? vl : vlmax_s[9:0];
  assign skip_s   = (vstart >= eff_vl_s);

  // Next-state logic; capture only fires once per alu_done level thanks to the armed flag.
  always_comb begin
    state_n   = state_r;
    capture_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (alu_done && armed_r) begin
          capture_s = 1'b1;
          state_n   = skip_s ? DONE : MERGE;
        end else begin
          state_n = IDLE;
        end
      end
      MERGE: begin
        if (w_r == LAST_W) state_n = WRITE;
        else               state_n = MERGE;
      end
      WRITE: begin
        if (wr_ready) state_n = DONE;
        else          state_n = WRITE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Per-byte merge of the current word; every byte of an element shares the same decision.
  always_comb begin
    alu_w_s      = alu_r[{w_r, 5'd0} +: 32];
    old_w_s      = old_r[{w_r, 5'd0} +: 32];
    merged_s     = old_w_s;
    elem_s       = 10'd0;
    act_s        = 1'b1;
    inact_ones_s = 1'b0;
    for (int b = 0; b < 4; b++) begin
      elem_s = 10'({w_r, 2'(b)}) >> sew_r;
`ifdef VEC_WB_MASK_EN
      act_s        = vm_r | mask_r[elem_s[IW-1:0]];
      inact_ones_s = vma_r;
`else
      act_s        = 1'b1;
      inact_ones_s = 1'b0;
`endif
      if (elem_s < vstart_r) begin
        merged_s[8*b +: 8] = old_w_s[8*b +: 8];
      end else if (elem_s < eff_vl_r) begin
        if (act_s)             merged_s[8*b +: 8] = alu_w_s[8*b +: 8];
        else if (inact_ones_s) merged_s[8*b +: 8] = 8'hFF;
        else                   merged_s[8*b +: 8] = old_w_s[8*b +: 8];
      end else if (vta_r) begin
        merged_s[8*b +: 8] = 8'hFF;
      end else begin
        merged_s[8*b +: 8] = old_w_s[8*b +: 8];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_r <= IDLE;
    else         state_r <= state_n;
  end

  // Armed flag, operand capture, word counter and merged-register accumulation.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      armed_r  <= 1'b1;
      sew_r    <= 2'd0;
      eff_vl_r <= 10'd0;
      vstart_r <= 10'd0;
      alu_r    <= {VLEN{1'b0}};
      old_r    <= {VLEN{1'b0}};
      vta_r    <= 1'b0;
      w_r      <= {WW{1'b0}};
      wr_addr  <= 5'd0;
      wr_data  <= {VLEN{1'b0}};
`ifdef VEC_WB_MASK_EN
      mask_r   <= {VLEN{1'b0}};
      vm_r     <= 1'b0;
      vma_r    <= 1'b0;
`endif
    end else begin
      if (capture_s) begin
        armed_r  <= 1'b0;
        sew_r    <= sew_s;
        eff_vl_r <= eff_vl_s;
        vstart_r <= vstart;
        alu_r    <= alu_vd;
        old_r    <= old_vd;
        vta_r    <= vta;
        w_r      <= {WW{1'b0}};
        wr_addr  <= vd_addr;
`ifdef VEC_WB_MASK_EN
        mask_r   <= v0_mask;
        vm_r     <= vm;
        vma_r    <= vma;
`endif
      end else if (state_r == IDLE && !alu_done) begin
        armed_r <= 1'b1;
      end
      if (state_r == MERGE) begin
        wr_data[{w_r, 5'd0} +: 32] <= merged_s;
        w_r                        <= w_r + WW'(1);
      end
    end
  end

  // Status outputs registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_valid <= 1'b0;
      alu_ack  <= 1'b0;
      wb_done  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      wr_valid <= (state_n == WRITE);
      alu_ack  <= (state_n == DONE);
      wb_done  <= (state_n == DONE);
      busy     <= (state_n != IDLE);
    end
  end
endmodule

// File: tb/tb_vec_wb_merge.sv
// Directed bench for vec_wb_merge: element-level reference model, per-cycle output compare,
// and literal expectations for each hand-worked vector.
module tb_vec_wb_merge;
  localparam int VLEN = 128;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            alu_done = 1'b0;
  logic [VLEN-1:0] alu_vd = '0, old_vd = '0, v0_mask = '0;
  logic            vm = 1'b1;
  logic [2:0]      vsew = 3'd0;
  logic [9:0]      vl = 10'd0, vstart = 10'd0;
  logic            vta = 1'b0, vma = 1'b0;
  logic [4:0]      vd_addr = 5'd0;
  logic            wr_valid;
  logic [4:0]      wr_addr;
  logic [VLEN-1:0] wr_data;
  logic            wr_ready = 1'b1;
  logic            alu_ack, busy, wb_done;

  int total = 0;
  int bad = 0;
  logic [VLEN-1:0] exp_data = '0, last_data = '0;
  logic [4:0]      exp_addr = 5'd0;
  logic            exp_skip = 1'b0, pending = 1'b0, wrote = 1'b0, hs_seen = 1'b0, prev_v = 1'b0;

  vec_wb_merge #(.VLEN(VLEN)) dut (
    .clk(clk), .resetn(resetn), .alu_done(alu_done), .alu_vd(alu_vd), .old_vd(old_vd),
    .v0_mask(v0_mask), .vm(vm), .vsew(vsew), .vl(vl), .vstart(vstart), .vta(vta), .vma(vma),
    .vd_addr(vd_addr), .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .alu_ack(alu_ack), .busy(busy), .wb_done(wb_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [VLEN-1:0] act, input logic [VLEN-1:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: walk elements of the configured width and apply the policy rules directly.
  function automatic void model(output logic [VLEN-1:0] res, output logic skip);
    int ew, vlmax, evl;
    ew    = (vsew == 3'd0) ? 8 : (vsew == 3'd1) ? 16 : 32;
    vlmax = VLEN / ew;
    evl   = (int'(vl) < vlmax) ? int'(vl) : vlmax;
    skip  = (int'(vstart) >= evl);
    res   = old_vd;
    for (int i = 0; i < vlmax; i++) begin
      logic ones, take;
      ones = 1'b0;
      take = 1'b0;
      if (i >= int'(vstart)) begin
        if (i < evl) begin
`ifdef VEC_WB_MASK_EN
          if (vm || v0_mask[i]) take = 1'b1;
          else                  ones = vma;
`else
          take = 1'b1;
`endif
        end else begin
          ones = vta;
        end
      end
      for (int k = 0; k < ew; k++) begin
        if (take)      res[i*ew+k] = alu_vd[i*ew+k];
        else if (ones) res[i*ew+k] = 1'b1;
      end
    end
  endfunction

  always @(posedge clk) hs_seen = wr_valid && wr_ready;

  // Per-cycle compare against the scoreboard.
  always @(negedge clk) begin
    if (!resetn) begin
      prev_v = 1'b0;
    end else begin
      if (wr_valid) begin
        check("wr_data", wr_data, exp_data);
        check("wr_addr", VLEN'(wr_addr), VLEN'(exp_addr));
        check("write_expected", VLEN'(pending && !exp_skip), VLEN'(1'b1));
        last_data = wr_data;
        wrote = 1'b1;
      end
      if (prev_v && !hs_seen) check("wr_valid_hold", VLEN'(wr_valid), VLEN'(1'b1));
      if (wb_done) begin
        check("done_expected", VLEN'(pending), VLEN'(1'b1));
        check("write_iff_not_skip", VLEN'(wrote), VLEN'(!exp_skip));
        check("alu_ack_with_done", VLEN'(alu_ack), VLEN'(1'b1));
        pending = 1'b0;
      end
      prev_v = wr_valid;
    end
  end

  task automatic setup(input logic [2:0] s, input logic [9:0] l, input logic [9:0] st,
                       input logic m, input logic ta, input logic ma, input logic [VLEN-1:0] a,
                       input logic [VLEN-1:0] o, input logic [VLEN-1:0] mk, input logic [4:0] ad);
    vsew = s; vl = l; vstart = st; vm = m; vta = ta; vma = ma;
    alu_vd = a; old_vd = o; v0_mask = mk; vd_addr = ad;
  endtask

  // Launch one operation, scramble inputs after capture, optionally stall, measure wb_done latency.
  task automatic run(input string name, input int exp_lat, input int stall, input int hold);
    int n, held;
    logic got;
    model(exp_data, exp_skip);
    exp_addr  = vd_addr;
    wrote     = 1'b0;
    pending   = 1'b1;
    last_data = '0;
    n = 0; held = 0; got = 1'b0;
    wr_ready = (stall > 0) ? 1'b0 : 1'b1;
    alu_done = 1'b1;
    while (!got && n < 40) begin
      @(posedge clk); @(negedge clk); n++;
      if (n == 1) begin
        alu_vd = ~alu_vd; old_vd = ~old_vd; v0_mask = ~v0_mask;
        vl = 10'd3; vstart = 10'd0; vsew = vsew ^ 3'b001; vd_addr = vd_addr + 5'd1;
      end
      if (wr_valid && stall > 0) begin
        if (held == stall) wr_ready = 1'b1;
        else               held++;
      end
      got = wb_done;
    end
    check({name, "_latency"}, VLEN'(n), VLEN'(exp_lat));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      check({name, "_no_recapture"}, VLEN'(busy), VLEN'(1'b0));
    end
    wr_ready = 1'b1;
    alu_done = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_wr_valid"}, VLEN'(wr_valid), VLEN'(1'b0));
    check({name, "_wr_addr"},  VLEN'(wr_addr),  VLEN'(5'd0));
    check({name, "_wr_data"},  wr_data,         VLEN'(0));
    check({name, "_alu_ack"},  VLEN'(alu_ack),  VLEN'(1'b0));
    check({name, "_busy"},     VLEN'(busy),     VLEN'(1'b0));
    check({name, "_wb_done"},  VLEN'(wb_done),  VLEN'(1'b0));
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_outputs("reset");
    resetn = 1'b1;
    @(negedge clk);

    setup(3'd0, 10'd16, 10'd0, 1'b1, 1'b0, 1'b0, {16{8'h0F}}, '0, '0, 5'd3);
    run("t1_sew8", 6, 0, 0);
    check("t1_data", last_data, {16{8'h0F}});

    setup(3'd2, 10'd2, 10'd0, 1'b1, 1'b1, 1'b0, 128'h11111111_22222222_33333333_44444444, '0, '0, 5'd7);
    run("t2_vta1", 6, 0, 0);
    check("t2_data", last_data, 128'hFFFFFFFF_FFFFFFFF_33333333_44444444);

    setup(3'd2, 10'd2, 10'd0, 1'b1, 1'b0, 1'b0, 128'h11111111_22222222_33333333_44444444, '0, '0, 5'd7);
    run("t3_vta0", 6, 0, 0);
    check("t3_data", last_data, 128'h00000000_00000000_33333333_44444444);

    setup(3'd1, 10'd8, 10'd0, 1'b0, 1'b0, 1'b0, {8{16'hA5A5}}, {8{16'h1234}}, 128'h00AA, 5'd9);
    run("t4_mask", 6, 0, 0);
`ifdef VEC_WB_MASK_EN
    check("t4_data", last_data, {4{32'hA5A5_1234}});
`else
    check("t4_data", last_data, {8{16'hA5A5}});
`endif

    setup(3'd0, 10'd5, 10'd5, 1'b1, 1'b0, 1'b0, {16{8'h77}}, {16{8'h33}}, '0, 5'd11);
    run("t5_skip", 1, 0, 5);

    setup(3'd0, 10'd10, 10'd2, 1'b1, 1'b1, 1'b0, 128'h00112233_44556677_8899AABB_CCDDEEFF,
          {16{8'h5A}}, '0, 5'd17);
    run("t6_stall", 9, 3, 0);
    check("t6_data", last_data, 128'hFFFFFFFF_FFFF6677_8899AABB_CCDD5A5A);

    setup(3'd7, 10'd3, 10'd1, 1'b1, 1'b0, 1'b0, 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD,
          128'h11111111_22222222_33333333_44444444, '0, 5'd21);
    run("t7_sew_rsvd", 6, 0, 0);
    check("t7_data", last_data, 128'h11111111_BBBBBBBB_CCCCCCCC_44444444);

    setup(3'd0, 10'd100, 10'd0, 1'b1, 1'b1, 1'b0, 128'h01234567_89ABCDEF_FEDCBA98_76543210, '0, '0, 5'd30);
    run("t8_vl_clamp", 6, 0, 0);
    check("t8_data", last_data, 128'h01234567_89ABCDEF_FEDCBA98_76543210);

    // Reset during MERGE word 2: outputs clear immediately and nothing follows.
    setup(3'd0, 10'd16, 10'd0, 1'b1, 1'b0, 1'b0, {16{8'hC3}}, '0, '0, 5'd5);
    pending  = 1'b0;
    alu_done = 1'b1;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    resetn = 1'b0;
    #1;
    check_idle_outputs("t9_abort");
    alu_done = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    check("t9_idle_after", VLEN'(busy), VLEN'(1'b0));

    setup(3'd0, 10'd16, 10'd0, 1'b1, 1'b0, 1'b0, {16{8'h0F}}, '0, '0, 5'd3);
    run("t10_recover", 6, 0, 0);
    check("t10_data", last_data, {16{8'h0F}});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
